axi_xi_mem_responder: RTL and testbench

Synthesizable AXI4 memory-mapped responder (slave) for the 64-bit Xi port. It terminates AW/W/B and AR/R bursts issued by a Xi initiator into a parameterized on-chip word array. It sits in the 250 MHz box as the local Xi endpoint and serves as the self-checking target for Xi-initiator simulations. Independent write and read engines each handle one outstanding burst and may run concurrently.

---
 rtl/axi_xi_mem_responder.sv | 238 +++++++++++++++++++++++
 tb/tb_axi_xi_mem_responder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_xi_mem_responder.sv
// AXI4 responder for the 64-bit Xi port, backed by an on-chip word array.
// Independent write and read engines, one outstanding burst each.
module axi_xi_mem_responder #(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 48
) (
   input  logic              axis_aclk,
   input  logic              mod_rstn,
   input  logic [ADDR_W-1:0] s_axi_Xi_awaddr,
   input  logic [7:0]        s_axi_Xi_awlen,
   input  logic [2:0]        s_axi_Xi_awsize,
   input  logic [1:0]        s_axi_Xi_awburst,
   input  logic              s_axi_Xi_awvalid,
   output logic              s_axi_Xi_awready,
   input  logic [63:0]       s_axi_Xi_wdata,
   input  logic [7:0]        s_axi_Xi_wstrb,
   input  logic              s_axi_Xi_wlast,
   input  logic              s_axi_Xi_wvalid,
   output logic              s_axi_Xi_wready,
   output logic [1:0]        s_axi_Xi_bresp,
   output logic              s_axi_Xi_bvalid,
   input  logic              s_axi_Xi_bready,
   input  logic [ADDR_W-1:0] s_axi_Xi_araddr,
   input  logic [7:0]        s_axi_Xi_arlen,
   input  logic [2:0]        s_axi_Xi_arsize,
   input  logic [1:0]        s_axi_Xi_arburst,
   input  logic              s_axi_Xi_arvalid,
   output logic              s_axi_Xi_arready,
   output logic [63:0]       s_axi_Xi_rdata,
   output logic [1:0]        s_axi_Xi_rresp,
   output logic              s_axi_Xi_rlast,
   output logic              s_axi_Xi_rvalid,
   input  logic              s_axi_Xi_rready
);

   localparam int IDX_W  = $clog2(DEPTH);
   localparam int SIDX_W = ADDR_W - 3;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_DATA = 2'd1;
   localparam logic [1:0] W_RESP = 2'd2;

   localparam logic [0:0] R_IDLE = 1'b0;
   localparam logic [0:0] R_DATA = 1'b1;

   // Range check is done on the full word index so huge addresses never alias into the array.
   function automatic logic [1:0] checkBurst(input logic [SIDX_W-1:0] startIdx,
                                             input logic [7:0]        len,
                                             input logic [2:0]        size,
                                             input logic [1:0]        burst);
      logic [SIDX_W:0] lastIdx;
      lastIdx = {1'b0, startIdx} + {{(SIDX_W-7){1'b0}}, len};
      if (lastIdx >= (SIDX_W+1)'(DEPTH)) return RESP_DECERR;
      if ((size != 3'd3) || burst[1])    return RESP_SLVERR;
      return RESP_OKAY;
   endfunction

   logic [63:0] mem [DEPTH];

   logic [1:0]       wState_q, wState_d;
   logic [IDX_W-1:0] wIdx_q, wIdx_d;
   logic [7:0]       wLen_q, wLen_d;
   logic [7:0]       wCnt_q, wCnt_d;
   logic             wFixed_q, wFixed_d;
   logic [1:0]       wResp_q, wResp_d;
   logic             awready_q, wready_q, bvalid_q;
   logic             wHs, wFinal;

   logic [0:0]       rState_q, rState_d;
   logic [IDX_W-1:0] rIdx_q, rIdx_d;
   logic [7:0]       rLen_q, rLen_d;
   logic [7:0]       rCnt_q, rCnt_d;
   logic             rFixed_q, rFixed_d;
   logic [1:0]       rResp_q, rResp_d;
   logic             rLast_q, rLast_d;
   logic             arready_q, rvalid_q;
   logic [63:0]      rdata_q;
   logic             rLoad;

   logic             unusedBits;
   assign unusedBits = ^{s_axi_Xi_awaddr[2:0], s_axi_Xi_araddr[2:0]};

   assign wHs    = wready_q & s_axi_Xi_wvalid;
   assign wFinal = (wCnt_q == wLen_q);

   always_comb begin
      wState_d = wState_q;
      wIdx_d   = wIdx_q;
      wLen_d   = wLen_q;
      wCnt_d   = wCnt_q;
      wFixed_d = wFixed_q;
      wResp_d  = wResp_q;
      case (wState_q)
         W_IDLE: begin
            if (awready_q && s_axi_Xi_awvalid) begin
               wIdx_d   = s_axi_Xi_awaddr[3 +: IDX_W];
               wLen_d   = s_axi_Xi_awlen;
               wCnt_d   = 8'd0;
               wFixed_d = (s_axi_Xi_awburst == 2'b00);
               wResp_d  = checkBurst(s_axi_Xi_awaddr[ADDR_W-1:3], s_axi_Xi_awlen,
                                     s_axi_Xi_awsize, s_axi_Xi_awburst);
               wState_d = W_DATA;
            end
         end
         W_DATA: begin
            if (wHs) begin
               if ((s_axi_Xi_wlast != wFinal) && (wResp_q == RESP_OKAY)) wResp_d = RESP_SLVERR;
               if (wFinal) begin
                  wState_d = W_RESP;
               end else begin
                  wCnt_d = wCnt_q + 8'd1;
                  if (!wFixed_q) wIdx_d = wIdx_q + IDX_W'(1);
               end
            end
         end
         W_RESP: begin
            if (bvalid_q && s_axi_Xi_bready) wState_d = W_IDLE;
         end
         default: wState_d = W_IDLE;
      endcase
   end

   // Handshake flags are registered from the next state so every output is zero while in reset.
   always_ff @(posedge axis_aclk) begin
      if (!mod_rstn) begin
         wState_q  <= W_IDLE;
         wIdx_q    <= '0;
         wLen_q    <= 8'd0;
         wCnt_q    <= 8'd0;
         wFixed_q  <= 1'b0;
         wResp_q   <= RESP_OKAY;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
      end else begin
         wState_q  <= wState_d;
         wIdx_q    <= wIdx_d;
         wLen_q    <= wLen_d;
         wCnt_q    <= wCnt_d;
         wFixed_q  <= wFixed_d;
         wResp_q   <= wResp_d;
         awready_q <= (wState_d == W_IDLE);
         wready_q  <= (wState_d == W_DATA);
         bvalid_q  <= (wState_d == W_RESP);
      end
   end

   // A beat is committed only while the burst is still OKAY; the beat revealing a wlast error still lands.
   always_ff @(posedge axis_aclk) begin
      if (mod_rstn && wHs && (wResp_q == RESP_OKAY)) begin
         for (int b = 0; b < 8; b++) begin
            if (s_axi_Xi_wstrb[b]) mem[wIdx_q][8*b +: 8] <= s_axi_Xi_wdata[8*b +: 8];
         end
      end
   end

   always_comb begin
      rState_d = rState_q;
      rIdx_d   = rIdx_q;
      rLen_d   = rLen_q;
      rCnt_d   = rCnt_q;
      rFixed_d = rFixed_q;
      rResp_d  = rResp_q;
      rLast_d  = rLast_q;
      rLoad    = 1'b0;
      case (rState_q)
         R_IDLE: begin
            if (arready_q && s_axi_Xi_arvalid) begin
               rIdx_d   = s_axi_Xi_araddr[3 +: IDX_W];
               rLen_d   = s_axi_Xi_arlen;
               rCnt_d   = 8'd0;
               rFixed_d = (s_axi_Xi_arburst == 2'b00);
               rResp_d  = checkBurst(s_axi_Xi_araddr[ADDR_W-1:3], s_axi_Xi_arlen,
                                     s_axi_Xi_arsize, s_axi_Xi_arburst);
               rLast_d  = (s_axi_Xi_arlen == 8'd0);
               rLoad    = 1'b1;
               rState_d = R_DATA;
            end
         end
         R_DATA: begin
            if (rvalid_q && s_axi_Xi_rready) begin
               if (rLast_q) begin
                  rLast_d  = 1'b0;
                  rState_d = R_IDLE;
               end else begin
                  rCnt_d  = rCnt_q + 8'd1;
                  if (!rFixed_q) rIdx_d = rIdx_q + IDX_W'(1);
                  rLast_d = ((rCnt_q + 8'd1) == rLen_q);
                  rLoad   = 1'b1;
               end
            end
         end
         default: rState_d = R_IDLE;
      endcase
   end

   // The next beat is fetched on the handshake edge itself, giving back-to-back beats.
   always_ff @(posedge axis_aclk) begin
      if (!mod_rstn) begin
         rState_q  <= R_IDLE;
         rIdx_q    <= '0;
         rLen_q    <= 8'd0;
         rCnt_q    <= 8'd0;
         rFixed_q  <= 1'b0;
         rResp_q   <= RESP_OKAY;
         rLast_q   <= 1'b0;
         rdata_q   <= 64'h0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
      end else begin
         rState_q  <= rState_d;
         rIdx_q    <= rIdx_d;
         rLen_q    <= rLen_d;
         rCnt_q    <= rCnt_d;
         rFixed_q  <= rFixed_d;
         rResp_q   <= rResp_d;
         rLast_q   <= rLast_d;
         arready_q <= (rState_d == R_IDLE);
         rvalid_q  <= (rState_d == R_DATA);
         if (rLoad) rdata_q <= (rResp_d == RESP_OKAY) ? mem[rIdx_d] : 64'h0;
      end
   end

   assign s_axi_Xi_awready = awready_q;
   assign s_axi_Xi_wready  = wready_q;
   assign s_axi_Xi_bvalid  = bvalid_q;
   assign s_axi_Xi_bresp   = wResp_q;
   assign s_axi_Xi_arready = arready_q;
   assign s_axi_Xi_rvalid  = rvalid_q;
   assign s_axi_Xi_rresp   = rResp_q;
   assign s_axi_Xi_rlast   = rLast_q;
   assign s_axi_Xi_rdata   = rdata_q;

endmodule

// File: tb/tb_axi_xi_mem_responder.sv
// Self-checking bench for axi_xi_mem_responder: directed scenarios plus randomized
// bursts compared against a word-array reference model.
module tb_axi_xi_mem_responder;

   localparam int DEPTH = 256;

   logic        axis_aclk = 1'b0;
   logic        mod_rstn;
   logic [47:0] awaddr, araddr;
   logic [7:0]  awlen, arlen;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst;
   logic        awvalid, awready, arvalid, arready;
   logic [63:0] wdata, rdata;
   logic [7:0]  wstrb;
   logic        wlast, wvalid, wready;
   logic [1:0]  bresp, rresp;
   logic        bvalid, bready, rlast, rvalid, rready;

   logic [63:0] modelMem [DEPTH];
   logic [63:0] wrData [256];
   logic [7:0]  wrStrb [256];
   int          errors = 0;
   int          checks = 0;

   axi_xi_mem_responder #(.DEPTH(DEPTH), .ADDR_W(48)) dut (
      .axis_aclk(axis_aclk), .mod_rstn(mod_rstn),
      .s_axi_Xi_awaddr(awaddr), .s_axi_Xi_awlen(awlen), .s_axi_Xi_awsize(awsize),
      .s_axi_Xi_awburst(awburst), .s_axi_Xi_awvalid(awvalid), .s_axi_Xi_awready(awready),
      .s_axi_Xi_wdata(wdata), .s_axi_Xi_wstrb(wstrb), .s_axi_Xi_wlast(wlast),
      .s_axi_Xi_wvalid(wvalid), .s_axi_Xi_wready(wready),
      .s_axi_Xi_bresp(bresp), .s_axi_Xi_bvalid(bvalid), .s_axi_Xi_bready(bready),
      .s_axi_Xi_araddr(araddr), .s_axi_Xi_arlen(arlen), .s_axi_Xi_arsize(arsize),
      .s_axi_Xi_arburst(arburst), .s_axi_Xi_arvalid(arvalid), .s_axi_Xi_arready(arready),
      .s_axi_Xi_rdata(rdata), .s_axi_Xi_rresp(rresp), .s_axi_Xi_rlast(rlast),
      .s_axi_Xi_rvalid(rvalid), .s_axi_Xi_rready(rready)
   );

   always #2 axis_aclk = ~axis_aclk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not end, got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] expResp(input logic [47:0] addr, input logic [7:0] len,
                                          input logic [2:0] size, input logic [1:0] burst);
      longint startIdx;
      startIdx = longint'(addr >> 3);
      if (startIdx + longint'(len) >= longint'(DEPTH)) return 2'b11;
      if (size != 3'd3 || burst == 2'b10 || burst == 2'b11) return 2'b10;
      return 2'b00;
   endfunction

   task automatic writeBurst(input logic [47:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input int earlyLast);
      logic [1:0] curResp;
      int         startIdx, idx, waitCnt, dly;
      bit         hs;
      curResp  = expResp(addr, len, size, burst);
      startIdx = int'(addr >> 3);
      awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
      hs = 0; waitCnt = 0;
      while (!hs && waitCnt < 20) begin
         @(negedge axis_aclk); hs = awready; @(posedge axis_aclk); #1; waitCnt++;
      end
      awvalid = 1'b0;
      if (!hs) begin checkOutput("awTimeout", 0, 1); return; end
      @(negedge axis_aclk);
      checkOutput("wreadyAfterAw", {awready, wready}, 2'b01);
      @(posedge axis_aclk); #1;
      for (int b = 0; b <= int'(len); b++) begin
         wdata = wrData[b]; wstrb = wrStrb[b];
         wlast = (b == int'(len)) || (b == earlyLast);
         if ($urandom_range(3) == 0) begin wvalid = 1'b0; @(posedge axis_aclk); #1; end
         wvalid = 1'b1; hs = 0; waitCnt = 0;
         while (!hs && waitCnt < 20) begin
            @(negedge axis_aclk); hs = wready; @(posedge axis_aclk); #1; waitCnt++;
         end
         if (!hs) begin wvalid = 1'b0; checkOutput("wTimeout", 0, 1); return; end
         idx = (burst == 2'b01) ? startIdx + b : startIdx;
         if (curResp == 2'b00) begin
            for (int k = 0; k < 8; k++)
               if (wrStrb[b][k]) modelMem[idx][8*k +: 8] = wrData[b][8*k +: 8];
            if (wlast != (b == int'(len))) curResp = 2'b10;
         end
      end
      wvalid = 1'b0; wlast = 1'b0;
      @(negedge axis_aclk);
      checkOutput("bvalidAfterLastW", {wready, bvalid}, 2'b01);
      dly = $urandom_range(2);
      for (int d = 0; d < dly; d++) begin
         @(posedge axis_aclk); #1; @(negedge axis_aclk);
         checkOutput("bvalidHold", {bvalid, bresp}, {1'b1, curResp});
      end
      @(posedge axis_aclk); #1; bready = 1'b1;
      @(negedge axis_aclk);
      checkOutput("bresp", {bvalid, bresp}, {1'b1, curResp});
      @(posedge axis_aclk); #1; bready = 1'b0;
      @(negedge axis_aclk);
      checkOutput("awreadyAfterB", {awready, bvalid}, 2'b10);
      @(posedge axis_aclk); #1;
   endtask

   task automatic readBurst(input logic [47:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input int mode);
      logic [1:0]  eResp;
      logic [63:0] eData;
      int          startIdx, idx, waitCnt, beat, cyc;
      bit          hs;
      eResp    = expResp(addr, len, size, burst);
      startIdx = int'(addr >> 3);
      araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
      hs = 0; waitCnt = 0;
      while (!hs && waitCnt < 20) begin
         @(negedge axis_aclk); hs = arready; @(posedge axis_aclk); #1; waitCnt++;
      end
      arvalid = 1'b0;
      if (!hs) begin checkOutput("arTimeout", 0, 1); return; end
      beat = 0; cyc = 0;
      while (beat <= int'(len) && cyc < 400) begin
         case (mode)
            0:       rready = 1'b1;
            1:       rready = (cyc % 2 == 0);
            default: rready = 1'($urandom_range(1));
         endcase
         @(negedge axis_aclk);
         if (cyc == 0) checkOutput("rvalidAfterAr", {arready, rvalid}, 2'b01);
         if (rvalid && rready) begin
            idx   = (burst == 2'b01) ? startIdx + beat : startIdx;
            eData = (eResp == 2'b00) ? modelMem[idx] : 64'h0;
            checkOutput("rdata", rdata, eData);
            checkOutput("rresp", rresp, eResp);
            checkOutput("rlast", rlast, (beat == int'(len)));
            beat++;
         end
         @(posedge axis_aclk); #1; cyc++;
      end
      rready = 1'b0;
      if (beat <= int'(len)) begin checkOutput("rTimeout", 0, 1); return; end
      @(negedge axis_aclk);
      checkOutput("arreadyAfterR", {arready, rvalid}, 2'b10);
      @(posedge axis_aclk); #1;
   endtask

   task automatic fillRandom(input int len, input bit fullStrb);
      for (int b = 0; b <= len; b++) begin
         wrData[b] = {$urandom, $urandom};
         wrStrb[b] = fullStrb ? 8'hff : 8'($urandom);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput(tag, {awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp}, 10'h0);
      checkOutput("rdataInReset", rdata, 64'h0);
   endtask

   task automatic applyStimulus();
      logic [47:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      bit          hs;
      int          waitCnt;

      repeat (4) @(posedge axis_aclk);
      @(negedge axis_aclk);
      checkAllZero("outputsInReset");
      @(posedge axis_aclk); #1; mod_rstn = 1'b1;
      @(posedge axis_aclk);
      @(negedge axis_aclk);
      checkOutput("readyAfterReset", {awready, arready, wready, bvalid, rvalid}, 5'b11000);
      @(posedge axis_aclk); #1;

      for (int b = 0; b < 16; b++) begin wrData[b] = 64'(b); wrStrb[b] = 8'hff; end
      writeBurst(48'h0, 8'd15, 3'd3, 2'b01, -1);
      readBurst(48'h0, 8'd15, 3'd3, 2'b01, 0);

      for (int blk = 1; blk < DEPTH / 16; blk++) begin
         fillRandom(15, 1'b1);
         writeBurst(48'(blk * 16 * 8), 8'd15, 3'd3, 2'b01, -1);
      end

      wrData[0] = 64'h1122334455667788; wrStrb[0] = 8'hff;
      writeBurst(48'd40, 8'd0, 3'd3, 2'b01, -1);
      wrData[0] = 64'hAAAAAAAAAAAAAAAA; wrStrb[0] = 8'h0f;
      writeBurst(48'd40, 8'd0, 3'd3, 2'b01, -1);
      readBurst(48'd40, 8'd0, 3'd3, 2'b01, 0);
      checkOutput("word5Merge", modelMem[5], 64'h11223344AAAAAAAA);

      for (int b = 0; b < 4; b++) begin wrData[b] = 64'(b + 1); wrStrb[b] = 8'hff; end
      writeBurst(48'd80, 8'd3, 3'd3, 2'b00, -1);
      readBurst(48'd80, 8'd3, 3'd3, 2'b01, 2);

      fillRandom(3, 1'b1);
      writeBurst(48'((DEPTH - 2) * 8), 8'd3, 3'd3, 2'b01, -1);
      readBurst(48'((DEPTH - 2) * 8), 8'd1, 3'd3, 2'b01, 0);
      readBurst(48'((DEPTH - 2) * 8), 8'd3, 3'd3, 2'b01, 0);
      readBurst(48'h0, 8'd3, 3'd2, 2'b01, 0);
      readBurst(48'h0, 8'd3, 3'd3, 2'b10, 0);
      fillRandom(1, 1'b1);
      writeBurst(48'd96, 8'd1, 3'd3, 2'b11, -1);
      readBurst(48'd96, 8'd1, 3'd3, 2'b01, 0);

      readBurst(48'(16 * 8), 8'd7, 3'd3, 2'b01, 1);

      fillRandom(7, 1'b1);
      fork
         writeBurst(48'h0, 8'd7, 3'd3, 2'b01, -1);
         readBurst(48'(8 * 8), 8'd7, 3'd3, 2'b01, 2);
      join
      readBurst(48'h0, 8'd7, 3'd3, 2'b01, 0);

      for (int i = 0; i < 24; i++) begin
         addr  = 48'($urandom_range(127)) * 48'd8 + 48'($urandom_range(7));
         len   = 8'($urandom_range(15));
         burst = 2'($urandom_range(1));
         size  = ($urandom_range(7) == 0) ? 3'd2 : 3'd3;
         if (i % 2 == 0) begin
            fillRandom(int'(len), 1'b0);
            writeBurst(addr, len, size, burst, -1);
         end else begin
            if ($urandom_range(5) == 0) burst = 2'b10;
            readBurst(addr, len, size, burst, int'($urandom_range(2)));
         end
      end

      fillRandom(3, 1'b1);
      writeBurst(48'(200 * 8), 8'd3, 3'd3, 2'b01, 1);

      fillRandom(7, 1'b1);
      awaddr = 48'(40 * 8); awlen = 8'd7; awsize = 3'd3; awburst = 2'b01; awvalid = 1'b1;
      hs = 0; waitCnt = 0;
      while (!hs && waitCnt < 20) begin
         @(negedge axis_aclk); hs = awready; @(posedge axis_aclk); #1; waitCnt++;
      end
      awvalid = 1'b0;
      if (!hs) checkOutput("awTimeoutRst", 0, 1);
      for (int b = 0; b < 3 && hs; b++) begin
         wdata = wrData[b]; wstrb = 8'hff; wlast = 1'b0; wvalid = 1'b1;
         hs = 0; waitCnt = 0;
         while (!hs && waitCnt < 20) begin
            @(negedge axis_aclk); hs = wready; @(posedge axis_aclk); #1; waitCnt++;
         end
         if (hs) modelMem[40 + b] = wrData[b];
         else checkOutput("wTimeoutRst", 0, 1);
      end
      wvalid = 1'b0; mod_rstn = 1'b0;
      @(posedge axis_aclk); #1;
      @(negedge axis_aclk);
      checkAllZero("outputsMidReset");
      @(posedge axis_aclk); #1; mod_rstn = 1'b1;
      @(posedge axis_aclk);
      @(negedge axis_aclk);
      checkOutput("readyAfterMidReset", {awready, arready, wready, bvalid, rvalid}, 5'b11000);
      @(posedge axis_aclk); #1;
      readBurst(48'(40 * 8), 8'd7, 3'd3, 2'b01, 0);
   endtask

   initial begin
      mod_rstn = 1'b0;
      awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
      applyStimulus();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
